// File: rtl/iter_alu_pkg.sv
// Shared definitions for the iterative ALU.
//   op_t      : 4-bit operation code carried on the operand bus
//   OP_*      : operation code values
//   state_t   : control FSM states (IDLE, BUSY, DONE)
//   op_is_div : op is one of the two divides
//   op_is_iter: op normally runs on the iterative multiply/divide unit
package iter_alu_pkg;

   typedef logic [3:0] op_t;

   localparam op_t OP_SLL  = 4'd0;
   localparam op_t OP_SRA  = 4'd1;
   localparam op_t OP_SRL  = 4'd2;
   localparam op_t OP_MUL  = 4'd3;
   localparam op_t OP_DIVU = 4'd4;
   localparam op_t OP_ADD  = 4'd5;
   localparam op_t OP_SUB  = 4'd6;
   localparam op_t OP_AND  = 4'd7;
   localparam op_t OP_OR   = 4'd8;
   localparam op_t OP_XOR  = 4'd9;
   localparam op_t OP_NOR  = 4'd10;
   localparam op_t OP_SLT  = 4'd11;
   localparam op_t OP_SLTU = 4'd12;
   localparam op_t OP_MULU = 4'd13;
   localparam op_t OP_DIV  = 4'd14;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic op_is_div(input op_t op);
      return (op == OP_DIVU) || (op == OP_DIV);
   endfunction

   function automatic logic op_is_iter(input op_t op);
      return (op == OP_MUL) || (op == OP_MULU) || op_is_div(op);
   endfunction

endpackage

// File: rtl/iter_alu_if.sv
// Operand/result bus of the iterative ALU.
//   in_valid/in_ready   : operand handshake (x, y, op travel with it)
//   out_valid/out_ready : result handshake (r, r2, of, uof, dz, equal travel with it)
//   master : the pipeline stage issuing ops and consuming results
//   slave  : the ALU
interface iter_alu_if
   import iter_alu_pkg::*;
#(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   op_t              op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] r2;
   logic             of;
   logic             uof;
   logic             dz;
   logic             equal;

   modport master (
      output in_valid, x, y, op, out_ready,
      input  in_ready, out_valid, r, r2, of, uof, dz, equal
   );

   modport slave (
      input  in_valid, x, y, op, out_ready,
      output in_ready, out_valid, r, r2, of, uof, dz, equal
   );
endinterface

// File: rtl/iter_alu_muldiv.sv
// Unsigned iterative multiplier / restoring divider, one bit per cycle.
// Both algorithms share a single WIDTH+1 bit adder and one step counter.
//   clk, rst_n : clock, synchronous active-low reset (control state only)
//   start      : load a/b and begin WIDTH steps
//   is_div     : 1 = divide a/b, 0 = multiply a*b
//   a, b       : unsigned operands (multiplicand/dividend, multiplier/divisor)
//   done       : high during the last step; hi/lo then show the final result
//   hi, lo     : next-step value of the working registers
//                (product high/low, or remainder/quotient)
module iter_alu_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   logic             run;
   logic [CW-1:0]    count;
   logic             div_mode;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] hi_nxt;
   logic [WIDTH-1:0] lo_nxt;
   logic [WIDTH:0]   add_a;
   logic [WIDTH:0]   add_b;
   logic [WIDTH:0]   add_s;
   logic             add_cin;

   // Multiply: accumulate b into hi when the current multiplier bit (lo[0]) is set.
   // Divide: trial-subtract b from the remainder shifted left by one dividend bit.
   always_comb begin
      if (div_mode) begin
         add_a   = {hi_q, lo_q[WIDTH-1]};
         add_b   = ~{1'b0, b_q};
         add_cin = 1'b1;
      end else begin
         add_a   = {1'b0, hi_q};
         add_b   = lo_q[0] ? {1'b0, b_q} : '0;
         add_cin = 1'b0;
      end
   end

   assign add_s = add_a + add_b + {{WIDTH{1'b0}}, add_cin};

   // For the divide the remainder stays below b, so add_s[WIDTH] is the borrow
   // of the trial subtraction: set means restore the shifted remainder.
   always_comb begin
      hi_nxt = hi_q;
      lo_nxt = lo_q;
      if (div_mode) begin
         if (add_s[WIDTH]) begin
            hi_nxt = add_a[WIDTH-1:0];
            lo_nxt = {lo_q[WIDTH-2:0], 1'b0};
         end else begin
            hi_nxt = add_s[WIDTH-1:0];
            lo_nxt = {lo_q[WIDTH-2:0], 1'b1};
         end
      end else begin
         hi_nxt = add_s[WIDTH:1];
         lo_nxt = {add_s[0], lo_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run   <= 1'b0;
         count <= '0;
      end else if (start) begin
         run   <= 1'b1;
         count <= '0;
      end else if (run) begin
         count <= count + CW'(1);
         if (count == LAST) begin
            run <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         div_mode <= is_div;
         b_q      <= b;
         hi_q     <= '0;
         lo_q     <= a;
      end else if (run) begin
         hi_q <= hi_nxt;
         lo_q <= lo_nxt;
      end
   end

   // The owner captures hi/lo in the same edge that retires the last step,
   // so the result is exposed one register stage early.
   assign done = run && (count == LAST);
   assign hi   = hi_nxt;
   assign lo   = lo_nxt;

endmodule

// File: rtl/iter_alu.sv
// Registered ALU with valid/ready handshakes on both sides.
// Shift, add/sub, logic and compare ops complete one cycle after accept;
// multiply and divide iterate one bit per cycle in iter_alu_muldiv.
//   clk   : clock, all state on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of iter_alu_if
//           in : in_valid, x, y, op, out_ready
//           out: in_ready, out_valid, r, r2, of, uof, dz, equal
module iter_alu
   import iter_alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   iter_alu_if.slave bus
);
   localparam int               SHW     = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONES    = '1;

   state_t state;
   state_t state_nxt;
   logic   in_ready_c;
   logic   out_valid_c;
   logic   accept;
   logic   div_by_zero;
   logic   iter_acc;
   logic   signed_op;

   logic signed [WIDTH-1:0] xs;
   logic signed [WIDTH-1:0] ys;
   logic [SHW-1:0]          sh;
   logic [WIDTH:0]          add_w;
   logic [WIDTH:0]          sub_w;
   logic [WIDTH-1:0]        mag_x;
   logic [WIDTH-1:0]        mag_y;

   logic [WIDTH-1:0] alu_r;
   logic [WIDTH-1:0] alu_r2;
   logic             alu_of;
   logic             alu_uof;
   logic             alu_dz;

   logic             md_done;
   logic [WIDTH-1:0] md_hi;
   logic [WIDTH-1:0] md_lo;

   logic               isdiv_p1;
   logic               qneg_p1;
   logic               rneg_p1;
   logic               ovf_p1;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r2_q;
   logic             of_q;
   logic             uof_q;
   logic             dz_q;
   logic             eq_q;

   // A finished result frees the unit in the same cycle it is consumed.
   assign in_ready_c  = (state == IDLE) || ((state == DONE) && bus.out_ready);
   assign accept      = bus.in_valid && in_ready_c;
   assign div_by_zero = op_is_div(bus.op) && (bus.y == '0);
   assign iter_acc    = op_is_iter(bus.op) && !div_by_zero;
   assign signed_op   = (bus.op == OP_MUL) || (bus.op == OP_DIV);

   always_comb begin
      state_nxt   = state;
      out_valid_c = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = iter_acc ? BUSY : DONE;
         end
         BUSY: begin
            if (md_done) state_nxt = DONE;
         end
         DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) state_nxt = accept ? (iter_acc ? BUSY : DONE) : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---- accept stage: single-cycle datapath on the live bus operands ----
   assign xs    = bus.x;
   assign ys    = bus.y;
   assign sh    = bus.y[SHW-1:0];
   assign add_w = {1'b0, bus.x} + {1'b0, bus.y};
   assign sub_w = {1'b0, bus.x} - {1'b0, bus.y};

   always_comb begin
      alu_r   = '0;
      alu_r2  = '0;
      alu_of  = 1'b0;
      alu_uof = 1'b0;
      alu_dz  = 1'b0;
      case (bus.op)
         OP_SLL:  alu_r = bus.x << sh;
         OP_SRA:  alu_r = xs >>> sh;
         OP_SRL:  alu_r = bus.x >> sh;
         OP_ADD: begin
            alu_r   = add_w[WIDTH-1:0];
            alu_uof = add_w[WIDTH];
            alu_of  = (bus.x[WIDTH-1] == bus.y[WIDTH-1]) && (add_w[WIDTH-1] != bus.x[WIDTH-1]);
         end
         OP_SUB: begin
            alu_r   = sub_w[WIDTH-1:0];
            alu_uof = sub_w[WIDTH];
            alu_of  = (bus.x[WIDTH-1] != bus.y[WIDTH-1]) && (sub_w[WIDTH-1] != bus.x[WIDTH-1]);
         end
         OP_AND:  alu_r = bus.x & bus.y;
         OP_OR:   alu_r = bus.x | bus.y;
         OP_XOR:  alu_r = bus.x ^ bus.y;
         OP_NOR:  alu_r = ~(bus.x | bus.y);
         OP_SLT:  alu_r = {{(WIDTH-1){1'b0}}, (xs < ys)};
         OP_SLTU: alu_r = {{(WIDTH-1){1'b0}}, (bus.x < bus.y)};
         // Only reached on this path when y==0: divide by zero short-cut.
         OP_DIVU, OP_DIV: begin
            alu_r  = ONES;
            alu_r2 = bus.x;
            alu_dz = 1'b1;
         end
         default: alu_r = '0;
      endcase
   end

   // Signed ops iterate on magnitudes; -MIN wraps to MIN, which is the
   // correct unsigned magnitude 2**(WIDTH-1).
   assign mag_x = (signed_op && bus.x[WIDTH-1]) ? -bus.x : bus.x;
   assign mag_y = (signed_op && bus.y[WIDTH-1]) ? -bus.y : bus.y;

   iter_alu_muldiv #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (accept && iter_acc),
      .is_div (op_is_div(bus.op)),
      .a      (mag_x),
      .b      (mag_y),
      .done   (md_done),
      .hi     (md_hi),
      .lo     (md_lo)
   );

   // Sign information captured at accept for the final fix-up.
   always_ff @(posedge clk) begin
      if (accept) begin
         isdiv_p1 <= op_is_div(bus.op);
         qneg_p1  <= signed_op && (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
         rneg_p1  <= signed_op && bus.x[WIDTH-1];
         ovf_p1   <= (bus.op == OP_DIV) && (bus.x == MIN_VAL) && (bus.y == ONES);
      end
   end

   // ---- completion stage: sign fix-up of the iterative result ----
   // Remainder follows the dividend's sign; MIN/-1 needs no special value,
   // the magnitude path already yields quotient MIN and remainder 0.
   assign prod_fix = qneg_p1 ? -{md_hi, md_lo} : {md_hi, md_lo};
   assign quo_fix  = qneg_p1 ? -md_lo : md_lo;
   assign rem_fix  = rneg_p1 ? -md_hi : md_hi;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         r_q   <= '0;
         r2_q  <= '0;
         of_q  <= 1'b0;
         uof_q <= 1'b0;
         dz_q  <= 1'b0;
         eq_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            eq_q <= (bus.x == bus.y);
            if (!iter_acc) begin
               r_q   <= alu_r;
               r2_q  <= alu_r2;
               of_q  <= alu_of;
               uof_q <= alu_uof;
               dz_q  <= alu_dz;
            end
         end else if ((state == BUSY) && md_done) begin
            if (isdiv_p1) begin
               r_q  <= quo_fix;
               r2_q <= rem_fix;
            end else begin
               r_q  <= prod_fix[WIDTH-1:0];
               r2_q <= prod_fix[2*WIDTH-1:WIDTH];
            end
            of_q  <= ovf_p1;
            uof_q <= 1'b0;
            dz_q  <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.r         = r_q;
   assign bus.r2        = r2_q;
   assign bus.of        = of_q;
   assign bus.uof       = uof_q;
   assign bus.dz        = dz_q;
   assign bus.equal     = eq_q;

endmodule

// File: tb/tb_iter_alu.sv
// Directed self-checking bench for iter_alu at WIDTH=32.
module tb_iter_alu;
   import iter_alu_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   iter_alu_if #(.WIDTH(32)) bus ();

   iter_alu #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic take();
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   // exp_res is {r2,r}; exp_flags is {of,uof,dz,equal}; latency counts
   // cycles from the accept edge until out_valid is seen.
   task automatic do_op(input string tag, input op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_res,
                        input logic [3:0] exp_flags, input int exp_lat);
      int lat;
      @(negedge clk);
      bus.op       = op;
      bus.x        = a;
      bus.y        = b;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.x        = $urandom;
      bus.y        = $urandom;
      bus.op       = OP_ADD;
      lat = 1;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_res"}, {bus.r2, bus.r}, exp_res);
      chk({tag, "_flags"}, 64'({bus.of, bus.uof, bus.dz, bus.equal}), 64'(exp_flags));
      take();
   endtask

   initial begin
      logic seen;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.x         = '0;
      bus.y         = '0;
      bus.op        = OP_ADD;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hs", 64'({bus.out_valid, bus.in_ready}), 64'(2'b01));
      chk("rst_res", {bus.r2, bus.r}, 64'h0);
      chk("rst_flags", 64'({bus.of, bus.uof, bus.dz, bus.equal}), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // single-cycle ops
      do_op("add_of",   OP_ADD,  32'h7FFFFFFF, 32'h00000001, {32'h0, 32'h80000000}, 4'b1000, 1);
      do_op("add_cy",   OP_ADD,  32'hFFFFFFFF, 32'h00000001, {32'h0, 32'h00000000}, 4'b0100, 1);
      do_op("sub_bw",   OP_SUB,  32'h00000000, 32'h00000001, {32'h0, 32'hFFFFFFFF}, 4'b0100, 1);
      do_op("sub_of",   OP_SUB,  32'h80000000, 32'h00000001, {32'h0, 32'h7FFFFFFF}, 4'b1000, 1);
      do_op("slt",      OP_SLT,  32'hFFFFFFFF, 32'h00000001, {32'h0, 32'h00000001}, 4'b0000, 1);
      do_op("sltu",     OP_SLTU, 32'hFFFFFFFF, 32'h00000001, {32'h0, 32'h00000000}, 4'b0000, 1);
      do_op("sll",      OP_SLL,  32'h00000001, 32'h0000001F, {32'h0, 32'h80000000}, 4'b0000, 1);
      do_op("sra",      OP_SRA,  32'h80000000, 32'h00000124, {32'h0, 32'hF8000000}, 4'b0000, 1);
      do_op("srl",      OP_SRL,  32'h80000000, 32'h0000001F, {32'h0, 32'h00000001}, 4'b0000, 1);
      do_op("and_eq",   OP_AND,  32'h00001234, 32'h00001234, {32'h0, 32'h00001234}, 4'b0001, 1);
      do_op("or",       OP_OR,   32'h00FF0000, 32'h000000FF, {32'h0, 32'h00FF00FF}, 4'b0000, 1);
      do_op("xor",      OP_XOR,  32'hA5A5A5A5, 32'hFFFF0000, {32'h0, 32'h5A5AA5A5}, 4'b0000, 1);
      do_op("nor",      OP_NOR,  32'hF0F0F0F0, 32'h0F0F0000, {32'h0, 32'h00000F0F}, 4'b0000, 1);
      do_op("undef",    4'd15,   32'h00000005, 32'h00000005, {32'h0, 32'h00000000}, 4'b0001, 1);
      chk("idle_after_take", 64'({bus.out_valid, bus.in_ready}), 64'(2'b01));

      // divide by zero short-cut
      do_op("divu_z",   OP_DIVU, 32'd100,      32'h0,        {32'd100, 32'hFFFFFFFF}, 4'b0010, 1);
      do_op("div_z",    OP_DIV,  32'd5,        32'h0,        {32'd5,   32'hFFFFFFFF}, 4'b0010, 1);

      // iterative ops
      do_op("mul",      OP_MUL,  32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1, 4'b0000, 33);
      do_op("mulu",     OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 4'b0001, 33);
      do_op("mul_min",  OP_MUL,  32'h80000000, 32'h80000000, 64'h40000000_00000000, 4'b0001, 33);
      do_op("divu",     OP_DIVU, 32'd100,      32'd7,        {32'd2, 32'd14},       4'b0000, 33);
      do_op("divu_max", OP_DIVU, 32'hFFFFFFFF, 32'd1,        {32'd0, 32'hFFFFFFFF}, 4'b0000, 33);
      do_op("div_nn",   OP_DIV,  32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 4'b0000, 33);
      do_op("div_pn",   OP_DIV,  32'd7,        32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD},  4'b0000, 33);
      do_op("div_ovf",  OP_DIV,  32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000},  4'b1000, 33);

      // result held under back-pressure, then back-to-back accept on release
      @(negedge clk);
      bus.op       = OP_ADD;
      bus.x        = 32'd2;
      bus.y        = 32'd3;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("hold_first", 64'({bus.out_valid, bus.r}), {31'h0, 1'b1, 32'd5});
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("hold_stable", 64'({bus.out_valid, bus.in_ready, bus.r}), {30'h0, 2'b10, 32'd5});
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.op        = OP_SUB;
      bus.x         = 32'd10;
      bus.y         = 32'd4;
      #1;
      chk("release_ready", 64'(bus.in_ready), 64'h1);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      chk("b2b_res", 64'({bus.out_valid, bus.r}), {31'h0, 1'b1, 32'd6});
      take();

      // reset in the middle of a multiply
      @(negedge clk);
      bus.op       = OP_MUL;
      bus.x        = 32'd7;
      bus.y        = 32'd9;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_mid_hs", 64'({bus.out_valid, bus.in_ready}), 64'(2'b01));
      chk("rst_mid_res", {bus.r2, bus.r}, 64'h0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen = 1'b1;
      end
      chk("rst_mid_novalid", 64'(seen), 64'h0);

      do_op("post_rst", OP_MULU, 32'd7, 32'd9, {32'd0, 32'd63}, 4'b0000, 33);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
